// File: rtl/multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXECUTE/MEM/WB sequencer for an RV32I datapath.
// The optional memory wait timeout is enabled by defining MEM_TIMEOUT_EN.
// Without it the controller waits on mem_ready indefinitely and mem_err is 0.
module multicycle_ctrl #(
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       opcode,
  input  logic             branch_taken,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mem_sel_data,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_src,
  output logic             reg_write,
  output logic [2:0]       state,
  output logic             halted,
  output logic             mem_err,
  output logic [CNT_W-1:0] instret
);

  localparam logic [4:0] OP_LOAD   = 5'b00000;
  localparam logic [4:0] OP_STORE  = 5'b01000;
  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_JAL    = 5'b11011;
  localparam logic [4:0] OP_JALR   = 5'b11001;
  localparam logic [4:0] OP_REG    = 5'b01100;
  localparam logic [4:0] OP_LUI    = 5'b01101;
  localparam logic [4:0] OP_AUIPC  = 5'b00101;
  localparam logic [4:0] OP_IMM    = 5'b00100;

  typedef enum logic [2:0] {
    ST_FETCH   = 3'd0,
    ST_DECODE  = 3'd1,
    ST_EXECUTE = 3'd2,
    ST_MEM     = 3'd3,
    ST_WB      = 3'd4,
    ST_HALT    = 3'd5
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_instret;
  logic             r_halted;
  logic             w_legal;
  logic             w_limit;
  logic             w_timeout;
  logic             w_retire;
  logic             w_mem_req;
  logic             w_mem_we;
  logic             w_mem_sel_data;
  logic             w_ir_write;
  logic             w_pc_write;
  logic             w_pc_src;
  logic             w_reg_write;

  // Opcode legality check used at DECODE
  always_comb begin
    w_legal = 1'b0;
    case (opcode)
      OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR,
      OP_REG, OP_LUI, OP_AUIPC, OP_IMM: w_legal = 1'b1;
      default:                          w_legal = 1'b0;
    endcase
  end

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned WAIT_W = 8;

  logic [WAIT_W-1:0] r_wait;
  logic              r_mem_err;

  // Count consecutive wait cycles of the current request; any non-wait cycle clears it
  always_ff @(posedge clk) begin
    if (reset || !(w_mem_req && !mem_ready)) r_wait <= '0;
    else                                     r_wait <= r_wait + WAIT_W'(1);
  end

  // Sticky memory-timeout flag
  always_ff @(posedge clk) begin
    if (reset)          r_mem_err <= 1'b0;
    else if (w_timeout) r_mem_err <= 1'b1;
  end

  // This cycle is the TIMEOUT-th wait cycle; mem_ready still wins
  assign w_limit = (r_wait == WAIT_W'(TIMEOUT - 1));
  assign mem_err = r_mem_err;
`else
  assign w_limit = 1'b0;
  assign mem_err = 1'b0;
`endif

  // State register, retired-instruction counter and sticky halt flag
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_FETCH;
      r_instret <= '0;
      r_halted  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_retire)          r_instret <= r_instret + CNT_W'(1);
      if (w_next == ST_HALT) r_halted  <= 1'b1;
    end
  end

  // Next-state and strobe decode
  always_comb begin
    w_next         = r_state;
    w_mem_req      = 1'b0;
    w_mem_we       = 1'b0;
    w_mem_sel_data = 1'b0;
    w_ir_write     = 1'b0;
    w_pc_write     = 1'b0;
    w_pc_src       = 1'b0;
    w_reg_write    = 1'b0;
    w_retire       = 1'b0;
    w_timeout      = 1'b0;
    case (r_state)
      ST_FETCH: begin
        w_mem_req = 1'b1;
        if (mem_ready) begin
          w_ir_write = 1'b1;
          w_next     = ST_DECODE;
        end else if (w_limit) begin
          w_timeout = 1'b1;
          w_next    = ST_HALT;
        end
      end
      ST_DECODE: begin
        w_next = w_legal ? ST_EXECUTE : ST_HALT;
      end
      ST_EXECUTE: begin
        case (opcode)
          OP_LOAD, OP_STORE: w_next = ST_MEM;
          OP_BRANCH: begin
            w_pc_write = 1'b1;
            w_pc_src   = branch_taken;
            w_retire   = 1'b1;
            w_next     = ST_FETCH;
          end
          default: w_next = ST_WB;
        endcase
      end
      ST_MEM: begin
        w_mem_req      = 1'b1;
        w_mem_sel_data = 1'b1;
        w_mem_we       = (opcode == OP_STORE);
        if (mem_ready) begin
          if (opcode == OP_STORE) begin
            w_pc_write = 1'b1;
            w_retire   = 1'b1;
            w_next     = ST_FETCH;
          end else begin
            w_next = ST_WB;
          end
        end else if (w_limit) begin
          w_timeout = 1'b1;
          w_next    = ST_HALT;
        end
      end
      ST_WB: begin
        w_reg_write = 1'b1;
        w_pc_write  = 1'b1;
        w_pc_src    = (opcode == OP_JAL) || (opcode == OP_JALR);
        w_retire    = 1'b1;
        w_next      = ST_FETCH;
      end
      ST_HALT: w_next = ST_HALT;
      default: w_next = ST_FETCH;
    endcase
  end

  // Strobes are suppressed while reset is held
  assign mem_req      = w_mem_req      & ~reset;
  assign mem_we       = w_mem_we       & ~reset;
  assign mem_sel_data = w_mem_sel_data & ~reset;
  assign ir_write     = w_ir_write     & ~reset;
  assign pc_write     = w_pc_write     & ~reset;
  assign pc_src       = w_pc_src       & ~reset;
  assign reg_write    = w_reg_write    & ~reset;

  assign state   = r_state;
  assign halted  = r_halted;
  assign instret = r_instret;

endmodule
